// File: rtl/rtc_time_setter.sv
// ---------------------------------------------------------------------------
// rtc_time_setter
//   Time-set front end for the HH:MM:SS RTC. It debounces the three
//   active-low push buttons and adds auto-repeat to them. While man_switch is
//   up, the user edits a BCD copy of the live time. Lowering man_switch writes
//   the edited time back to the counters.
//
//   Ports
//     clock50MHz    in   system clock
//     reset_button  in   async active-low master reset
//     push_button   in   [2]=hours [1]=minutes [0]=seconds, active-low, async
//     man_switch    in   1 = manual set mode, async
//     cur_hh/mm/ss  in   live time, BCD {tens,ones}
//     set_hh/mm/ss  out  edited time, BCD
//     set_load      out  one-cycle strobe, counters load set_* on this cycle
//     editing       out  high in CAPTURE and EDIT
//
// rtc_time_setter_btn (one instance per button)
//   Samples the synchronised level on each tick, accepts a new level after
//   DEBOUNCE_LEN equal samples, and emits a one-cycle event on the press and
//   on each auto-repeat step.
//
//   Ports
//     clock50MHz  in   system clock
//     resetn      in   async active-low reset
//     tick        in   sample strobe
//     level       in   synchronised button level, active-low
//     evt         out  one-cycle press / repeat event
// ---------------------------------------------------------------------------

module rtc_time_setter_btn #(
    parameter int DEBOUNCE_LEN = 8,   // must be >= 2
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clock50MHz,
    input  logic resetn,
    input  logic tick,
    input  logic level,
    output logic evt
);
    localparam int CW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);

    logic [DEBOUNCE_LEN-1:0] samples, samples_nxt;
    logic                    pressed, pressed_nxt;
    logic                    repeating;
    logic [CW-1:0]           hold_cnt, hold_inc, hold_target;

    always_comb begin
        samples_nxt = (samples << 1) | DEBOUNCE_LEN'(level);
        pressed_nxt = pressed;
        if (samples_nxt == '0)
            pressed_nxt = 1'b1;
        else if (samples_nxt == '1)
            pressed_nxt = 1'b0;
        hold_inc    = hold_cnt + CW'(1);
        // First step waits REPEAT_DELAY ticks, later steps REPEAT_RATE ticks.
        hold_target = repeating ? RATE_C : DELAY_C;
    end

    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
            samples   <= '1;          // all-released history
            pressed   <= 1'b0;
            repeating <= 1'b0;
            hold_cnt  <= '0;
            evt       <= 1'b0;
        end else begin
            evt <= 1'b0;
            if (tick) begin
                samples <= samples_nxt;
                pressed <= pressed_nxt;
                // Decisions use the freshly debounced level so that a release
                // landing on a repeat tick does not emit a stray event.
                if (!pressed_nxt) begin
                    repeating <= 1'b0;
                    hold_cnt  <= '0;
                end else if (!pressed) begin
                    evt       <= 1'b1;
                    repeating <= 1'b0;
                    hold_cnt  <= '0;
                end else if (hold_inc == hold_target) begin
                    evt       <= 1'b1;
                    repeating <= 1'b1;
                    hold_cnt  <= '0;
                end else begin
                    hold_cnt  <= hold_inc;
                end
            end
        end
    end
endmodule

module rtc_time_setter #(
    parameter int TICK_DIV     = 49999,
    parameter int DEBOUNCE_LEN = 8,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       clock50MHz,
    input  logic       reset_button,
    input  logic [2:0] push_button,
    input  logic       man_switch,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    output logic [7:0] set_hh,
    output logic [7:0] set_mm,
    output logic [7:0] set_ss,
    output logic       set_load,
    output logic       editing
);
    localparam int NUM_BTN = 3;
    localparam int TW      = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, EDIT, COMMIT} state_t;

    logic               resetn;
    logic               man_meta, man_sync;
    logic [NUM_BTN-1:0] pb_meta, pb_sync;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] evt;

    state_t     state, state_nxt;
    logic [7:0] hh_nxt, mm_nxt, ss_nxt;
    logic       load_nxt, edit_nxt;

    assign resetn = reset_button;

    // 2-FF synchronisers; buttons idle high (released).
    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
            man_meta <= 1'b0;
            man_sync <= 1'b0;
            pb_meta  <= '1;
            pb_sync  <= '1;
        end else begin
            man_meta <= man_switch;
            man_sync <= man_meta;
            pb_meta  <= push_button;
            pb_sync  <= pb_meta;
        end
    end

    // Sample tick: high on the cycle the divider wraps.
    assign tick = (tick_cnt == TW'(TICK_DIV));

    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    rtc_time_setter_btn #(
        .DEBOUNCE_LEN (DEBOUNCE_LEN),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_btn [NUM_BTN-1:0] (
        .clock50MHz (clock50MHz),
        .resetn     (resetn),
        .tick       (tick),
        .level      (pb_sync),
        .evt        (evt)
    );

    // Fields are kept in range by the capture clamp, so only the top value
    // needs to wrap; ones==9 carries into tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Packed BCD compares correctly as binary once both digits are valid.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [7:0] top);
        if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v > top)
            return 8'h00;
        else
            return v;
    endfunction

    // Outputs are registered from the next state, so they line up with the
    // state they describe (editing high while in CAPTURE/EDIT, set_load high
    // while in COMMIT).
    always_comb begin
        state_nxt = state;
        hh_nxt    = set_hh;
        mm_nxt    = set_mm;
        ss_nxt    = set_ss;
        load_nxt  = 1'b0;
        edit_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (man_sync) begin
                    state_nxt = CAPTURE;
                    edit_nxt  = 1'b1;
                    hh_nxt    = bcd_clamp(cur_hh, 8'h23);
                    mm_nxt    = bcd_clamp(cur_mm, 8'h59);
                    ss_nxt    = bcd_clamp(cur_ss, 8'h59);
                end
            end
            CAPTURE: begin
                state_nxt = EDIT;
                edit_nxt  = 1'b1;
            end
            EDIT: begin
                if (!man_sync) begin
                    // Events on this cycle are dropped on purpose.
                    state_nxt = COMMIT;
                    load_nxt  = 1'b1;
                end else begin
                    edit_nxt = 1'b1;
                    if (evt[2]) hh_nxt = bcd_inc(set_hh, 8'h23);
                    if (evt[1]) mm_nxt = bcd_inc(set_mm, 8'h59);
                    if (evt[0]) ss_nxt = bcd_inc(set_ss, 8'h59);
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            set_hh   <= 8'h00;
            set_mm   <= 8'h00;
            set_ss   <= 8'h00;
            set_load <= 1'b0;
            editing  <= 1'b0;
        end else begin
            state    <= state_nxt;
            set_hh   <= hh_nxt;
            set_mm   <= mm_nxt;
            set_ss   <= ss_nxt;
            set_load <= load_nxt;
            editing  <= edit_nxt;
        end
    end
endmodule

// File: tb/tb_rtc_time_setter.sv
// ---------------------------------------------------------------------------
// tb_rtc_time_setter
//   Directed bench for rtc_time_setter. u_dut uses the short bench timing;
//   u_db uses DEBOUNCE_LEN=8 for the glitch-filter sequence and shares
//   man_switch / cur_* with u_dut.
// ---------------------------------------------------------------------------
module tb_rtc_time_setter;
    logic       clock50MHz = 1'b0;
    logic       reset_button;
    logic [2:0] push_button, push_button_db;
    logic       man_switch;
    logic [7:0] cur_hh, cur_mm, cur_ss;
    logic [7:0] set_hh, set_mm, set_ss;
    logic       set_load, editing;
    logic [7:0] db_hh, db_mm, db_ss;
    logic       db_load, db_editing;

    int checks = 0;
    int errors = 0;
    int cyc;

    typedef struct {
        logic [7:0] hh, mm, ss;
        logic [7:0] ehh, emm, ess;
    } cap_vec_t;

    typedef struct {
        logic [7:0] hh, mm, ss;
        logic [2:0] btn;
        logic [7:0] ehh, emm, ess;
    } inc_vec_t;

    cap_vec_t cap_tbl [7];
    inc_vec_t inc_tbl [6];

    always #5 clock50MHz = ~clock50MHz;

    // Posedges since reset release; the divider ticks when cyc%10==0.
    always @(posedge clock50MHz or negedge reset_button)
        if (!reset_button) cyc <= 0;
        else               cyc <= cyc + 1;

    rtc_time_setter #(
        .TICK_DIV(9), .DEBOUNCE_LEN(2), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) u_dut (
        .clock50MHz(clock50MHz), .reset_button(reset_button),
        .push_button(push_button), .man_switch(man_switch),
        .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_load(set_load), .editing(editing)
    );

    rtc_time_setter #(
        .TICK_DIV(9), .DEBOUNCE_LEN(8), .REPEAT_DELAY(500), .REPEAT_RATE(100)
    ) u_db (
        .clock50MHz(clock50MHz), .reset_button(reset_button),
        .push_button(push_button_db), .man_switch(man_switch),
        .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss),
        .set_hh(db_hh), .set_mm(db_mm), .set_ss(db_ss),
        .set_load(db_load), .editing(db_editing)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clock50MHz);
    endtask

    task automatic do_capture(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        cur_hh = hh; cur_mm = mm; cur_ss = ss;
        man_switch = 1'b1;
        cyc_wait(4);
    endtask

    task automatic do_commit(output int pulses);
        pulses = 0;
        man_switch = 1'b0;
        repeat (8) begin
            @(negedge clock50MHz);
            if (set_load) pulses++;
        end
    endtask

    // Waits for set_mm (sel=1) or set_ss (sel=0) to move off prev.
    task automatic wait_change(input bit sel, input logic [7:0] prev, output int n);
        n = 0;
        while (((sel ? set_mm : set_ss) == prev) && n < 300) begin
            @(negedge clock50MHz);
            n++;
        end
    endtask

    initial begin
        int p, n;
        logic [7:0] prev;

        reset_button = 1'b0; push_button = '1; push_button_db = '1; man_switch = 1'b0;
        cur_hh = 8'h12; cur_mm = 8'h34; cur_ss = 8'h56;

        cap_tbl[0] = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56};
        cap_tbl[1] = '{8'h12, 8'h7A, 8'h56, 8'h12, 8'h00, 8'h56};
        cap_tbl[2] = '{8'h24, 8'h60, 8'h60, 8'h00, 8'h00, 8'h00};
        cap_tbl[3] = '{8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59};
        cap_tbl[4] = '{8'h1F, 8'h09, 8'h5A, 8'h00, 8'h09, 8'h00};
        cap_tbl[5] = '{8'hA0, 8'h5F, 8'h07, 8'h00, 8'h00, 8'h07};
        cap_tbl[6] = '{8'h19, 8'h45, 8'h30, 8'h19, 8'h45, 8'h30};

        inc_tbl[0] = '{8'h12, 8'h34, 8'h59, 3'b001, 8'h12, 8'h34, 8'h00};
        inc_tbl[1] = '{8'h23, 8'h10, 8'h10, 3'b100, 8'h00, 8'h10, 8'h10};
        inc_tbl[2] = '{8'h09, 8'h09, 8'h00, 3'b110, 8'h10, 8'h10, 8'h00};
        inc_tbl[3] = '{8'h12, 8'h59, 8'h30, 3'b010, 8'h12, 8'h00, 8'h30};
        inc_tbl[4] = '{8'h19, 8'h59, 8'h09, 3'b101, 8'h20, 8'h59, 8'h10};
        inc_tbl[5] = '{8'h08, 8'h49, 8'h29, 3'b111, 8'h09, 8'h50, 8'h30};

        // Reset state
        cyc_wait(3);
        chk("rst_hh", set_hh, 8'h00);
        chk("rst_mm", set_mm, 8'h00);
        chk("rst_ss", set_ss, 8'h00);
        chk("rst_load", set_load, 1'b0);
        chk("rst_edit", editing, 1'b0);
        reset_button = 1'b1;
        cyc_wait(5);

        // Capture latency, clamping, commit strobe, IDLE hold
        foreach (cap_tbl[i]) begin
            cur_hh = cap_tbl[i].hh; cur_mm = cap_tbl[i].mm; cur_ss = cap_tbl[i].ss;
            man_switch = 1'b1;
            cyc_wait(2);
            chk($sformatf("cap%0d_edit_early", i), editing, 1'b0);
            cyc_wait(1);
            chk($sformatf("cap%0d_hh", i), set_hh, cap_tbl[i].ehh);
            chk($sformatf("cap%0d_mm", i), set_mm, cap_tbl[i].emm);
            chk($sformatf("cap%0d_ss", i), set_ss, cap_tbl[i].ess);
            chk($sformatf("cap%0d_edit", i), editing, 1'b1);
            cyc_wait(5);
            man_switch = 1'b0;
            cyc_wait(2);
            chk($sformatf("cmt%0d_load_early", i), set_load, 1'b0);
            cyc_wait(1);
            chk($sformatf("cmt%0d_load", i), set_load, 1'b1);
            chk($sformatf("cmt%0d_edit", i), editing, 1'b0);
            cyc_wait(1);
            chk($sformatf("cmt%0d_load_off", i), set_load, 1'b0);
            cur_hh = 8'h01; cur_mm = 8'h02; cur_ss = 8'h03;
            cyc_wait(4);
            chk($sformatf("idle%0d_hh", i), set_hh, cap_tbl[i].ehh);
            chk($sformatf("idle%0d_ss", i), set_ss, cap_tbl[i].ess);
        end

        // Single presses, wraps, simultaneous presses
        foreach (inc_tbl[i]) begin
            do_capture(inc_tbl[i].hh, inc_tbl[i].mm, inc_tbl[i].ss);
            push_button = ~inc_tbl[i].btn;
            cyc_wait(35);
            push_button = '1;
            cyc_wait(60);
            chk($sformatf("inc%0d_hh", i), set_hh, inc_tbl[i].ehh);
            chk($sformatf("inc%0d_mm", i), set_mm, inc_tbl[i].emm);
            chk($sformatf("inc%0d_ss", i), set_ss, inc_tbl[i].ess);
            do_commit(p);
            chk($sformatf("inc%0d_pulses", i), p, 1);
        end

        // Auto-repeat on minutes: events at ticks 0,5,7,9,11
        do_capture(8'h07, 8'h00, 8'h00);
        push_button = 3'b101;
        prev = set_mm;
        for (int k = 1; k <= 5; k++) begin
            wait_change(1'b1, prev, n);
            chk($sformatf("rep%0d_seen", k), n < 300, 1'b1);
            chk($sformatf("rep%0d_mm", k), set_mm, k);
            if (k == 2)     chk($sformatf("rep%0d_gap", k), n, 50);
            else if (k > 2) chk($sformatf("rep%0d_gap", k), n, 20);
            prev = set_mm;
        end
        push_button = '1;
        cyc_wait(150);
        chk("rep_release_mm", set_mm, 8'h05);
        chk("rep_hh", set_hh, 8'h07);
        chk("rep_ss", set_ss, 8'h00);
        do_commit(p);
        chk("rep_pulses", p, 1);

        // Repeat event landing on the commit-decision cycle is dropped
        do_capture(8'h00, 8'h00, 8'h00);
        push_button = 3'b110;
        prev = set_ss;
        for (int k = 1; k <= 3; k++) begin
            wait_change(1'b0, prev, n);
            chk($sformatf("drop_step%0d", k), set_ss, k);
            prev = set_ss;
        end
        // Next repeat applies 20 cycles after this one; man_switch low now
        // reaches the FSM on exactly that cycle.
        cyc_wait(17);
        do_commit(p);
        chk("drop_pulses", p, 1);
        chk("drop_ss", set_ss, 8'h03);
        push_button = '1;
        cyc_wait(60);
        chk("drop_idle_ss", set_ss, 8'h03);
        chk("drop_idle_edit", editing, 1'b0);

        // Glitch filter with DEBOUNCE_LEN=8 on u_db
        do_capture(8'h12, 8'h34, 8'h56);
        for (int b = 0; b < 20 && (cyc % 10) != 5; b++) @(negedge clock50MHz);
        for (int t = 0; t < 6; t++) begin
            push_button_db[0] = t[0];
            cyc_wait(10);
        end
        push_button_db[0] = 1'b0;
        cyc_wait(50);
        chk("db_early_ss", db_ss, 8'h56);
        cyc_wait(50);
        chk("db_ss", db_ss, 8'h57);
        push_button_db = '1;
        cyc_wait(120);
        chk("db_hold_ss", db_ss, 8'h57);
        chk("db_main_ss", set_ss, 8'h56);
        do_commit(p);
        chk("db_pulses", p, 1);

        // Reset mid-edit
        do_capture(8'h00, 8'h00, 8'h42);
        cyc_wait(2);
        chk("rst_pre_ss", set_ss, 8'h42);
        reset_button = 1'b0;
        #1;
        chk("rst_mid_ss", set_ss, 8'h00);
        chk("rst_mid_edit", editing, 1'b0);
        chk("rst_mid_load", set_load, 1'b0);
        man_switch = 1'b0;
        cyc_wait(2);
        reset_button = 1'b1;
        p = 0;
        repeat (20) begin
            @(negedge clock50MHz);
            if (set_load) p++;
        end
        chk("rst_no_load", p, 0);
        chk("rst_after_ss", set_ss, 8'h00);
        chk("rst_after_edit", editing, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
